// File: rtl/fsm_tx_pkg.sv
// Shared definitions for the fsm_tx byte sender: state encoding, bytes_sent width
// and a counter-width helper.
package fsm_tx_pkg;

  localparam int BYTES_SENT_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_POP       = 3'd1,
    ST_LOAD      = 3'd2,
    ST_START     = 3'd3,
    ST_WAIT_DONE = 3'd4,
    ST_CLEAN     = 3'd5
  } tx_state_e;

  // Bits needed to hold the values 0 .. max_val-1.
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val);
  endfunction

endpackage

// File: rtl/tx_timeout_cnt.sv
// Timeout counter for the WAIT_DONE phase: cleared by clr, counts while en is high,
// flags expired when the count reaches TIMEOUT_CYC-1 (counter saturates there).
module tx_timeout_cnt
  import fsm_tx_pkg::*;
#(
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = cnt_width(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != LAST)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = en && (cnt_q == LAST);

endmodule

// File: rtl/fsm_tx.sv
// fsm_tx: pops bytes from a TX FIFO and hands them to a UART transmitter after an
// 'enviar' command. Define FSM_TX_BURST_EN to drain the whole FIFO per command.
//
// Handshakes: fifo_tx_rd pops one entry and fifo_tx_dout is valid the following
// cycle; uart_tx_start is only issued while uart_tx_busy is low, and the byte is
// closed by a one-cycle uart_tx_done (or abandoned after TIMEOUT_CYC cycles).
module fsm_tx
  import fsm_tx_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enviar_cmd,
  output logic                    enviar_bit_clear,
  input  logic                    fifo_tx_empty,
  output logic                    fifo_tx_rd,
  input  logic [DATA_W-1:0]       fifo_tx_dout,
  output logic [DATA_W-1:0]       uart_tx_data,
  output logic                    uart_tx_start,
  input  logic                    uart_tx_busy,
  input  logic                    uart_tx_done,
  output logic                    tx_active,
  output logic                    tx_error,
  output logic [BYTES_SENT_W-1:0] bytes_sent,
  output tx_state_e               state_dbg
);

  tx_state_e               state_q, state_d;
  logic [DATA_W-1:0]       data_q, data_d;
  logic [BYTES_SENT_W-1:0] bytes_q, bytes_d;
  logic                    error_q, error_d;
  logic                    clear_q, clear_d;
  logic                    cnt_clr, cnt_en, cnt_expired;

  tx_timeout_cnt #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout (
    .clk    (clk),
    .rst_n  (rst),
    .clr    (cnt_clr),
    .en     (cnt_en),
    .expired(cnt_expired)
  );

  always_comb begin
    state_d       = state_q;
    data_d        = data_q;
    bytes_d       = bytes_q;
    error_d       = error_q;
    clear_d       = 1'b0;
    fifo_tx_rd    = 1'b0;
    uart_tx_start = 1'b0;
    cnt_clr       = 1'b1;
    cnt_en        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enviar_cmd) begin
          error_d = 1'b0;
          bytes_d = '0;
          state_d = fifo_tx_empty ? ST_CLEAN : ST_POP;
        end
      end
      ST_POP: begin
        fifo_tx_rd = 1'b1;
        state_d    = ST_LOAD;
      end
      ST_LOAD: begin
        data_d  = fifo_tx_dout;
        state_d = ST_START;
      end
      ST_START: begin
        // The start cycle already counts toward the timeout window.
        if (!uart_tx_busy) begin
          uart_tx_start = 1'b1;
          cnt_clr       = 1'b0;
          cnt_en        = 1'b1;
          state_d       = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        cnt_clr = 1'b0;
        cnt_en  = 1'b1;
        if (uart_tx_done) begin
          bytes_d = bytes_q + BYTES_SENT_W'(1);
`ifdef FSM_TX_BURST_EN
          state_d = fifo_tx_empty ? ST_CLEAN : ST_POP;
`else
          state_d = ST_CLEAN;
`endif
        end else if (cnt_expired) begin
          error_d = 1'b1;
          state_d = ST_CLEAN;
        end
      end
      ST_CLEAN: begin
        clear_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      bytes_q <= '0;
      error_q <= 1'b0;
      clear_q <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      bytes_q <= bytes_d;
      error_q <= error_d;
      clear_q <= clear_d;
    end
  end

  // The clear pulse is registered, so it lands in the cycle after CLEAN.
  assign enviar_bit_clear = clear_q;
  assign uart_tx_data     = data_q;
  assign bytes_sent       = bytes_q;
  assign tx_error         = error_q;
  assign tx_active        = (state_q != ST_IDLE);
  assign state_dbg        = state_q;

endmodule
